// File: rtl/mandel_iter_if.sv
// mandel_iter_if: start/done handshake and result bus between the pixel sequencer and mandel_iter.
interface mandel_iter_if #(
   parameter int BITS      = 16,
   parameter int ITER_BITS = 8
);
   logic                        start;
   logic signed [BITS-1:0]      cr;
   logic signed [BITS-1:0]      ci;
   logic        [ITER_BITS-1:0] max_iter;
   logic                        busy;
   logic                        done;
   logic        [ITER_BITS-1:0] iter;
   logic                        escaped;
   modport master (output start, cr, ci, max_iter, input busy, done, iter, escaped);
   modport slave  (input start, cr, ci, max_iter, output busy, done, iter, escaped);
endinterface

// File: rtl/mandel_iter.sv
// mandel_iter: sequential Mandelbrot iteration engine sharing one truncating multiplier over x*x, y*y and x*y.
module approx_mul #(
   parameter int BITS = 16
) (
   input  logic signed [BITS-1:0] i_a,
   input  logic signed [BITS-1:0] i_b,
   output logic signed [BITS+3:0] o_p
);
   logic signed [2*BITS-1:0] w_a, w_b;
   assign w_a = i_a;
   assign w_b = i_b;
   // Keep [5:-(BITS-2)] of the full product, truncating the low fraction bits.
   assign o_p = (BITS+4)'((w_a * w_b) >>> (BITS-4));
endmodule

module mandel_iter #(
   parameter int BITS      = 16,
   parameter int ITER_BITS = 8
) (
   input logic           clk,
   input logic           rst,
   mandel_iter_if.slave  bus
);
   localparam int P = BITS + 4;
   localparam logic signed [P:0] FOUR = {5'b00001, {BITS{1'b0}}};

   typedef enum logic [2:0] {IDLE, SQ_X, SQ_Y, CROSS, DONE} state_t;

   state_t                      r_state, w_next;
   logic signed [BITS-1:0]      r_x, r_y, r_cr, r_ci, w_ma, w_mb;
   logic signed [P-1:0]         r_xx, r_yy, w_prod, w_diff, w_cx, w_cy, w_xn, w_yn;
   logic signed [P:0]           w_mag;
   logic        [ITER_BITS-1:0] r_iter, r_max, w_iter1;
   logic                        r_esc, w_escape, w_ovf;

   assign w_ma = (r_state == SQ_Y) ? r_y : r_x;
   assign w_mb = (r_state == SQ_X) ? r_x : r_y;

   approx_mul #(.BITS(BITS)) u_mul (.i_a(w_ma), .i_b(w_mb), .o_p(w_prod));

   assign w_mag    = r_xx + r_yy;
   assign w_escape = w_mag >= FOUR;
   assign w_diff   = r_xx - r_yy;
   assign w_cx     = {{4{r_cr[BITS-1]}}, r_cr};
   assign w_cy     = {{4{r_ci[BITS-1]}}, r_ci};
   assign w_xn     = (w_diff >>> 1) + w_cx;
   assign w_yn     = w_prod + w_cy;
   // A new coordinate is in range only if its top bits are pure sign extension.
   assign w_ovf    = (w_xn[P-1:BITS-1] != {5{w_xn[BITS-1]}}) ||
                     (w_yn[P-1:BITS-1] != {5{w_yn[BITS-1]}});
   assign w_iter1  = r_iter + 1'b1;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? ((bus.max_iter == '0) ? DONE : SQ_X) : IDLE;
         SQ_X:    w_next = SQ_Y;
         SQ_Y:    w_next = CROSS;
         CROSS:   w_next = (w_escape || w_ovf || w_iter1 == r_max) ? DONE : SQ_X;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_xx    <= '0;
         r_yy    <= '0;
         r_cr    <= '0;
         r_ci    <= '0;
         r_max   <= '0;
         r_iter  <= '0;
         r_esc   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: if (bus.start) begin
               r_cr   <= bus.cr;
               r_ci   <= bus.ci;
               r_max  <= bus.max_iter;
               r_x    <= '0;
               r_y    <= '0;
               r_iter <= '0;
               r_esc  <= 1'b0;
            end
            SQ_X: r_xx <= w_prod;
            SQ_Y: r_yy <= w_prod;
            CROSS: if (w_escape) begin
               r_esc <= 1'b1;
            end else begin
               r_iter <= w_iter1;
               if (w_ovf) begin
                  r_esc <= 1'b1;
               end else begin
                  r_x <= w_xn[BITS-1:0];
                  r_y <= w_yn[BITS-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = r_state != IDLE;
   assign bus.done    = r_state == DONE;
   assign bus.iter    = r_iter;
   assign bus.escaped = r_esc;
endmodule

// File: doc/mandel_iter.md
# mandel_iter

Sequential Mandelbrot iteration engine that sits directly downstream of the shared approximate fixed-point multiplier. It owns one `approx_mul` instance and time-multiplexes it over x², y² and x·y. For one point c it iterates z ← z² + c from z₀ = 0 until escape or an iteration limit. It then reports the iteration count through a start/done handshake to the pixel sequencer.

## Interface
- `BITS`, 16, operand width; operands and c use signed format [2:-(BITS-3)], range [-4, 4), LSB 2^-(BITS-3)
- `ITER_BITS`, 8, width of iteration count and limit
- `clk` in 1: clock; one clock domain, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: request; accepted only in IDLE
- `cr` in BITS: real part of c, format [2:-(BITS-3)], sampled on accept
- `ci` in BITS: imaginary part of c, same format, sampled on accept
- `max_iter` in ITER_BITS: iteration limit, sampled on accept
- `busy` out 1: high in every non-IDLE state
- `done` out 1: one-cycle pulse, result valid
- `iter` out ITER_BITS: completed iterations
- `escaped` out 1: 1 = point escaped, 0 = limit reached

## Operation
- States are IDLE, SQ_X, SQ_Y, CROSS and DONE.
- **IDLE** with `start`=1:
  - Latch cr, ci and max_iter.
  - Set x=y=0, iter=0, escaped=0.
  - If max_iter==0 go to DONE; otherwise go to SQ_X.
- **SQ_X:** multiplier inputs (x, x). Register xx (full product, format [5:-(BITS-2)]). Go to SQ_Y.
- **SQ_Y:** multiplier inputs (y, y). Register yy. Go to CROSS.
- **CROSS:** multiplier inputs (x, y). Form mag = xx + yy at BITS+5 bits, then apply the first matching rule:
  - **Escape test:** if mag ≥ 4.0, set escaped=1, leave iter unchanged, go to DONE.
  - **Update:**
    - x' = (xx − yy) >>> 1 + sext(cr). Dropping the product's extra fraction bit aligns it to the operand LSB.
    - y' = product bit pattern reinterpreted at operand LSB (this equals 2xy) + sext(ci).
    - Compute both at BITS+4 bits.
    - iter ← iter+1.
  - **Overflow:** if x' or y' falls outside [-4, 4), set escaped=1 and go to DONE. x and y are not updated.
  - Otherwise x←x', y←y'. If iter+1 == max_iter go to DONE with escaped=0; otherwise go to SQ_X.
- **DONE:** `done`=1 for exactly this cycle; iter and escaped are stable. Go to IDLE.
- **Result hold:** iter and escaped hold their values in IDLE until the next accepted `start`.
- **start while busy:** ignored, including during DONE; it is not queued.
- **Truncation:** the escape test uses truncated products and no rounding. Multiplier error of ±1 LSB is accepted at the boundary.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `iter`=0, `escaped`=0. Internal x, y, xx and yy are cleared.
- **Reset mid-operation:** `rst` in any state returns to IDLE on that edge with all outputs at reset values. No `done` pulse is produced.
- **Acceptance:** `start` is sampled at edge 0; SQ_X is cycle 1 and `busy`=1 from cycle 1.
- **Iteration length:** each iteration takes exactly 3 cycles; CROSS of iteration k (0-based) is cycle 3k+3.
- **done cycle:**
  - Limit reached with max_iter=N: cycle 3N+1.
  - Escape test firing with iter=n: cycle 3n+4.
  - Overflow in iteration k: cycle 3k+4, iter=k+1.
  - max_iter=0: cycle 1.
- **Back-to-back:** the earliest next accept is the IDLE cycle following DONE.

## Test plan
- **c=0, max_iter=10:** `done` at cycle 31, iter=10, escaped=0, `busy` high cycles 1–31.
- **c=1.0+0i, max_iter=255:** z goes 0, 1, 2; |z₂|²=4 → `done` at cycle 10, iter=2, escaped=1.
- **c=1.9+0i:** z₂=5.51 overflows in iteration 1 → `done` at cycle 7, iter=2, escaped=1.
- **c=−1.0+0i, max_iter=50:** periodic, so iter=50, escaped=0, `done` at cycle 151.
- **Boundary cases:**
  - max_iter=0 → `done` at cycle 1, iter=0.
  - `start` pulsed during SQ_Y and during DONE is ignored; the result is unchanged.
- **Reset mid-operation:** `rst` asserted in CROSS of iteration 3 → next cycle `busy`=0, iter=0, no `done`. A fresh start with c=1.0 still gives iter=2.
